// File: rtl/fetch_pkg.sv
// Shared constants and the entry layout for the instruction fetch queue.
package fetch_pkg;

  localparam int unsigned FETCH_XLEN = 32;
  localparam logic [FETCH_XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Circular buffer with head/tail pointers, occupancy count and a flush input.
// The caller gates push and pop; flush overrides both.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = logic [63:0],
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  entry_t        wdata_i,
  output entry_t        rdata_o,
  output logic [CW-1:0] count_o
);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits, so +1 wraps at DEPTH for free.
      if (push_i) tail_d = tail_q + 1'b1;
      if (pop_i)  head_d = head_q + 1'b1;
      if (push_i && !pop_i)      count_d = count_q + 1'b1;
      else if (!push_i && pop_i) count_d = count_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage has no reset; entries are only observed while count > 0.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[tail_q] <= wdata_i;
  end

  assign rdata_o = mem_q[head_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Prefetch queue between instruction memory and decode: owns the fetch PC,
// gates pushes and pops, and handles execute-stage redirects.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     XLEN     = FETCH_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
  localparam int unsigned    CW       = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] PCF,
  input  logic [XLEN-1:0] InstrF,
  input  logic            FetchEnF,
  input  logic            RedirectE,
  input  logic [XLEN-1:0] TargetE,
  input  logic            StallD,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic            ValidD,
  output logic            FullF,
  output logic [CW-1:0]   CountF
);

  // Same {pc, instr} layout as fetch_entry_t, sized by this instance's XLEN.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   count;
  logic            push, pop;
  entry_t          wdata, head_entry;

  assign FullF  = (count == FULL_COUNT);
  assign ValidD = (count != '0);
  assign CountF = count;
  assign PCF    = pc_q;

  // Push is gated on the pre-pop count: a full queue never accepts a push,
  // even in a cycle where decode drains an entry.
  assign push = FetchEnF && !FullF && !RedirectE;
  assign pop  = ValidD && !StallD && !RedirectE;

  assign wdata = '{pc: pc_q, instr: InstrF};

  always_comb begin
    pc_d = pc_q;
    if (RedirectE) pc_d = {TargetE[XLEN-1:2], 2'b00};
    else if (push) pc_d = pc_q + PC_STEP;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  sync_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (RedirectE),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wdata),
    .rdata_o (head_entry),
    .count_o (count)
  );

  assign InstrD = head_entry.instr;
  assign PCD    = head_entry.pc;

endmodule
